// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: PC owner and fetch FSM feeding a 2-entry decode queue; define FETCH_ALIGN_CHECK_EN to trap misaligned redirects
module instr_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        align_err
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_pc;
  logic [1:0]  cnt_q, cnt_d;
  logic        head_q, head_d, tail_q, tail_d, align_q, mis, deq, cap;
  logic [31:0] inst_q [2];
  logic [31:0] ipc_q  [2];
`ifdef FETCH_ALIGN_CHECK_EN
  assign mis    = redirect && (redirect_pc[1:0] != 2'b00);
  assign tgt_pc = redirect_pc & ~32'h3;
`else
  assign mis    = 1'b0;
  assign tgt_pc = redirect_pc;
`endif
  assign imem_addr  = pc_q;
  assign inst_valid = cnt_q != 2'd0;
  assign inst_data  = inst_q[head_q];
  assign inst_pc    = ipc_q[head_q];
  assign busy       = state_q == RUN;
  assign align_err  = align_q;
  assign deq        = inst_valid && inst_ready;
  // a full queue can still accept when the head leaves on the same edge
  assign cap        = (state_q == RUN) && !redirect && ((cnt_q != 2'd2) || deq);
  always_comb begin
    state_d = redirect ? (mis ? HALT : state_q)
            : (state_q == RUN) ? (halt_req ? HALT : RUN)
            : (start && !align_q) ? RUN : state_q;
    pc_d    = redirect ? tgt_pc : cap ? pc_q + 32'(PC_STEP) : pc_q;
    cnt_d   = redirect ? 2'd0 : cnt_q + {1'b0, cap} - {1'b0, deq};
    head_d  = redirect ? 1'b0 : head_q ^ deq;
    tail_d  = redirect ? 1'b0 : tail_q ^ cap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      align_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= 32'h0;
        ipc_q[i]  <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      align_q <= align_q | mis;
      if (cap) begin
        inst_q[tail_q] <= imem_data;
        ipc_q[tail_q]  <= pc_q;
      end
    end
  end
endmodule
